// File: rtl/polar_encoder_n8.sv
// Non-systematic N=8 polar encoder: x = u * F^(x3), one butterfly stage per clock, 3-cycle latency.
// Holds the codeword until out_ready and accepts nothing while busy. Optional BPSK symbol outputs under POLAR_ENC_BPSK_EN.
`ifdef POLAR_ENC_BPSK_EN
`ifndef SIZE
`define SIZE 8
`endif
`endif

module polar_encoder_n8 #(
    parameter logic [7:0] FROZEN_MASK = 8'b0001_0111,
    parameter int         K           = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] info_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   code_out,
    output logic [15:0]  frame_cnt
`ifdef POLAR_ENC_BPSK_EN
    ,
    output logic signed [`SIZE-1:0] x1_out,
    output logic signed [`SIZE-1:0] x2_out,
    output logic signed [`SIZE-1:0] x3_out,
    output logic signed [`SIZE-1:0] x4_out,
    output logic signed [`SIZE-1:0] x5_out,
    output logic signed [`SIZE-1:0] x6_out,
    output logic signed [`SIZE-1:0] x7_out,
    output logic signed [`SIZE-1:0] x8_out
`endif
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ST1  = 3'd1;
    localparam logic [2:0] ST2  = 3'd2;
    localparam logic [2:0] ST3  = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;

    function automatic int count_zeros(input logic [7:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (!m[i]) n++;
        end
        return n;
    endfunction

    // Info bit index feeding unfrozen position i (number of unfrozen positions below i).
    function automatic int rank_of(input logic [7:0] m, input int pos);
        int n;
        n = 0;
        for (int i = 0; i < pos; i++) begin
            if (!m[i]) n++;
        end
        return n;
    endfunction

    // In-place butterfly of span d: v[j] ^= v[j+d] for j with bit d clear.
    function automatic logic [7:0] bfly(input logic [7:0] v, input logic [2:0] d);
        logic [7:0] r;
        logic [2:0] jj;
        r = v;
        for (int j = 0; j < 8; j++) begin
            jj = j[2:0];
            if ((jj & d) == 3'd0) r[jj] = v[jj] ^ v[jj | d];
        end
        return r;
    endfunction

    generate
        if (count_zeros(FROZEN_MASK) != K) begin : g_bad_k
            $error("polar_encoder_n8: K must equal the number of unfrozen positions");
        end
    endgenerate

    logic [2:0] state;
    logic [7:0] u;
    logic [7:0] u_load;
    logic [7:0] code_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_scatter
            if (!FROZEN_MASK[gi] && (rank_of(FROZEN_MASK, gi) < K)) begin : g_info
                assign u_load[gi] = info_in[rank_of(FROZEN_MASK, gi)];
            end else begin : g_frozen
                assign u_load[gi] = 1'b0;
            end
        end
    endgenerate

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == OUT);
    assign code_nxt  = bfly(u, 3'd4);

`ifdef POLAR_ENC_BPSK_EN
    logic signed [`SIZE-1:0] x_reg [8];

    assign x1_out = x_reg[0];
    assign x2_out = x_reg[1];
    assign x3_out = x_reg[2];
    assign x4_out = x_reg[3];
    assign x5_out = x_reg[4];
    assign x6_out = x_reg[5];
    assign x7_out = x_reg[6];
    assign x8_out = x_reg[7];

    // Positive symbol stands for bit 0, matching the decoder's LLR sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) x_reg[i] <= '0;
        end else if (state == ST3) begin
            for (int i = 0; i < 8; i++) x_reg[i] <= code_nxt[i] ? '1 : `SIZE'sd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            u         <= '0;
            code_out  <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        u     <= u_load;
                        state <= ST1;
                    end
                end
                ST1: begin
                    u     <= bfly(u, 3'd1);
                    state <= ST2;
                end
                ST2: begin
                    u     <= bfly(u, 3'd2);
                    state <= ST3;
                end
                ST3: begin
                    u        <= code_nxt;
                    code_out <= code_nxt;
                    state    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_encoder_n8.sv
// Directed bench for polar_encoder_n8: reset, codeword table, hold, mid-frame reset, back-to-back, counter wrap.
`ifdef POLAR_ENC_BPSK_EN
`ifndef SIZE
`define SIZE 8
`endif
`endif

module tb_polar_encoder_n8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  info_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  code_out;
    logic [15:0] frame_cnt;
`ifdef POLAR_ENC_BPSK_EN
    logic signed [`SIZE-1:0] x_o [8];
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    polar_encoder_n8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .info_in   (info_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_out  (code_out),
        .frame_cnt (frame_cnt)
`ifdef POLAR_ENC_BPSK_EN
        ,
        .x1_out    (x_o[0]),
        .x2_out    (x_o[1]),
        .x3_out    (x_o[2]),
        .x4_out    (x_o[3]),
        .x5_out    (x_o[4]),
        .x6_out    (x_o[5]),
        .x7_out    (x_o[6]),
        .x8_out    (x_o[7])
`endif
    );

    // Accept one info word (caller is at a negedge in IDLE); returns negedges until out_valid.
    task automatic send(input logic [3:0] info, output int lat);
        in_valid = 1'b1;
        info_in  = info;
        @(negedge clk);
        in_valid = 1'b0;
        info_in  = ~info;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; info_in = 4'h0;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || code_out !== 8'h00 || frame_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b code_out=%h frame_cnt=%h, want 0/0/00/0000",
                     in_ready, out_valid, code_out, frame_cnt);
        end
`ifdef POLAR_ENC_BPSK_EN
        vectors++;
        if (x_o[0] !== '0 || x_o[7] !== '0) begin
            miscompares++;
            $display("FAIL reset_bpsk: x1=%0d x8=%0d, want 0", x_o[0], x_o[7]);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
        end
        exp_cnt = 16'd0;
    endtask

    task automatic test_codewords();
        logic [3:0] infos [8];
        logic [7:0] codes [8];
        int lat;
        infos = '{4'b1111, 4'b0001, 4'b1000, 4'b0000, 4'b0101, 4'b1010, 4'b0010, 4'b0100};
        codes = '{8'h96,   8'h0F,   8'hFF,   8'h00,   8'h5A,   8'hCC,   8'h33,   8'h55};
        out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            send(infos[v], lat);
            // Accept edge, then three stage edges: OUT seen at the fourth negedge.
            vectors++;
            if (lat !== 4) begin
                miscompares++;
                $display("FAIL latency[%0d]: got %0d negedges, want 4", v, lat);
            end
            vectors++;
            if (code_out !== codes[v]) begin
                miscompares++;
                $display("FAIL code[%0d]: info=%b code_out=%h, want %h", v, infos[v], code_out, codes[v]);
            end
`ifdef POLAR_ENC_BPSK_EN
            for (int i = 0; i < 8; i++) begin
                logic signed [`SIZE-1:0] ex;
                ex = codes[v][i] ? -`SIZE'sd1 : `SIZE'sd1;
                vectors++;
                if (x_o[i] !== ex) begin
                    miscompares++;
                    $display("FAIL bpsk[%0d] x%0d: got %0d, want %0d", v, i + 1, x_o[i], ex);
                end
            end
`endif
            @(negedge clk);
            exp_cnt = exp_cnt + 16'd1;
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== exp_cnt) begin
                miscompares++;
                $display("FAIL handshake[%0d]: out_valid=%b in_ready=%b frame_cnt=%0d, want 0/1/%0d",
                         v, out_valid, in_ready, frame_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        int bad;
        out_ready = 1'b0;
        send(4'b0101, lat);
        vectors++;
        if (lat !== 4 || code_out !== 8'h5A) begin
            miscompares++;
            $display("FAIL hold_entry: lat=%0d code_out=%h, want 4/5a", lat, code_out);
        end
        in_valid = 1'b1;
        info_in  = 4'b1111;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || code_out !== 8'h5A || in_ready !== 1'b0 || frame_cnt !== exp_cnt) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold: %0d of 10 cycles wrong, last out_valid=%b code_out=%h in_ready=%b frame_cnt=%0d, want 1/5a/0/%0d",
                     bad, out_valid, code_out, in_ready, frame_cnt, exp_cnt);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b frame_cnt=%0d, want 0/1/%0d",
                     out_valid, in_ready, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        info_in   = 4'b1111;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL midrst_during: in_ready=%b out_valid=%b frame_cnt=%0d, want 0/0/0",
                     in_ready, out_valid, frame_cnt);
        end
        rst = 1'b0;
        exp_cnt = 16'd0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0 || in_ready !== 1'b1 || frame_cnt !== 16'h0 || code_out !== 8'h00) begin
            miscompares++;
            $display("FAIL midrst_after: out_valid seen %0d times, in_ready=%b frame_cnt=%0d code_out=%h, want 0/1/0/00",
                     seen, in_ready, frame_cnt, code_out);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        int t0;
        int cycles;
        out_ready = 1'b1;
        bad = 0;
        cycles = 0;
        t0 = 0;
        for (int f = 0; f < 20; f++) begin
            send(4'b1000, lat);
            cycles += lat;
            if (lat !== 4 || code_out !== 8'hFF) bad++;
            @(negedge clk);
            cycles++;
            exp_cnt = exp_cnt + 16'd1;
            if (in_ready !== 1'b1 || frame_cnt !== exp_cnt) bad++;
            t0++;
        end
        vectors++;
        if (bad != 0 || cycles != 5 * t0) begin
            miscompares++;
            $display("FAIL back_to_back: %0d bad frames, %0d cycles for %0d frames, want 0 and %0d",
                     bad, cycles, t0, 5 * t0);
        end
    endtask

    task automatic test_wrap();
        int lat;
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        vectors++;
        if (frame_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_preload: frame_cnt=%h, want ffff", frame_cnt);
        end
        out_ready = 1'b1;
        send(4'b0001, lat);
        @(negedge clk);
        vectors++;
        if (frame_cnt !== 16'h0000 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap: frame_cnt=%h out_valid=%b, want 0000/0", frame_cnt, out_valid);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; info_in = 4'h0;
        test_reset();
        test_codewords();
        test_hold();
        test_reset_mid_frame();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
